noise_layer_sequencer: RTL
==========================

// Module: noise_layer_sequencer
// PURPOSE
//  Schedules per-layer noise-matrix generation for the generator pipeline. Drives noise_matrix_filler
//  (start/size/done) into one of two ping-pong noise BRAM banks. Hands filled banks to the conv
//  consumer via a valid/release handshake. Prefetches layer i+1 into the free bank while layer i is consumed.
// PARAMETERS
//  DATA_WIDTH  16  noise word width (pass-through to filler; unused internally)
//  ADDR_WIDTH  14  filler BRAM address width; size code s = side (4<<s); s=0..5 fit 14 bits
//  WDOG_CYCLES 20000  fill-done timeout in cycles (NOISE_SEQ_WATCHDOG_EN only); must exceed 16384
// PORTS
//  clk            in   1  single clock, all logic rising-edge
//  rst_n          in   1  synchronous, active-low reset
//  cfg_start      in   1  1-cycle pulse: begin a sequence (sampled in IDLE only)
//  cfg_num_layers in   3  layers in sequence, 0..6
//  cfg_base_size  in   3  size code of layer 0; layer i uses base+i
//  busy           out  1  high from accepted cfg_start until done
//  done           out  1  1-cycle pulse, sequence complete
//  cfg_err        out  1  sticky; cleared by next accepted cfg_start
//  fill_start     out  1  1-cycle pulse to filler start
//  fill_size      out  3  size code to filler, stable from fill_start until fill_done
//  fill_bank      out  1  bank the filler writes (BRAM write-side mux select)
//  fill_done      in   1  filler done pulse
//  layer_valid    out  1  bank layer_bank holds layer layer_idx
//  layer_bank     out  1  bank to read
//  layer_size     out  3  size code of presented layer
//  layer_idx      out  3  layer number of presented layer
//  layer_release  in   1  consumer finished with presented bank (honoured only while layer_valid)
// BEHAVIOUR
//  Reset: every output 0; full[1:0]=0, wr_bank=rd_bank=0, fill_idx=rel_idx=0, FSMs idle; cfg_err cleared.
//  Top FSM: IDLE -> RUN on cfg_start; RUN -> FIN when rel_idx==num_layers; FIN -> IDLE (done=1 in FIN).
//   cfg_start in RUN/FIN ignored. num_layers==0: IDLE->FIN, done pulse next cycle, no fills.
//   base+num_layers-1 > 5 or num_layers > 6: stay IDLE, set cfg_err, no busy, no done. Config latched on accept.
//  Fill FSM (in RUN): F_IDLE -> F_START when fill_idx<num_layers && !full[wr_bank];
//   F_START drives fill_start=1 for exactly one cycle, fill_size=base+fill_idx, fill_bank=wr_bank;
//   F_START -> F_WAIT; on fill_done: full[wr_bank]<=1, wr_bank toggles, fill_idx++, -> F_IDLE.
//   fill_done outside F_WAIT ignored.
//  Latency: cfg_start at edge N -> fill_start high cycle N+2; fill_done at edge M -> layer_valid high cycle M+1.
//  Consumer: layer_valid = full[rd_bank] (registered); layer_bank=rd_bank, layer_size=base+rel_idx, layer_idx=rel_idx.
//   layer_release && layer_valid: full[rd_bank]<=0, rd_bank toggles, rel_idx++; layer_valid low at least next cycle.
//   Release without valid ignored.
//  Simultaneous fill_done (bank X) and release (bank !X): both applied same edge.
//  Freed bank re-fill: fill FSM samples registered full, so fill_start earliest 2 cycles after release.
//  Both banks full: fill FSM waits in F_IDLE (back-pressure); no overwrite of an unreleased bank.
//  Arithmetic: size code add is 3-bit, range-checked at accept, never wraps; counters 3-bit.
//  Reset mid-sequence: all state to reset values immediately; filler shares rst_n, no drain.
// CONFIGURATION
//  NOISE_SEQ_WATCHDOG_EN defined: 15-bit counter runs in F_WAIT; reaching WDOG_CYCLES sets cfg_err,
//   forces top FSM to IDLE (busy=0, no done, full cleared). Undefined: counter absent, F_WAIT waits forever.
// STRUCTURE
//  Shared package noise_pkg.vh: SIZE_MAX=5, MAX_LAYERS=6, size-code->side/word-count localparams,
//   top and fill FSM state encodings. Reused by noise_matrix_filler and bench.
//  Sub-module noise_bank_tracker: full[1:0], wr_bank/rd_bank pointers, set/clear/toggle logic.
// TESTING
//  base=0,num=1: fill_start once size=0 bank=0; done after fill_done+release; layer_idx=0.
//  base=2,num=3, consumer releases 5 cycles after valid: fill sizes 2,3,4, banks 0,1,0; layer_idx 0,1,2; one done.
//  base=0,num=4, consumer stalls: after 2 fills no fill_start until first release; then bank 0 refilled size 2.
//  fill_done and layer_release same edge: both banks update; no lost layer; rel_idx/fill_idx correct.
//  base=4,num=3 -> cfg_err=1, busy=0, no fill_start; num=0 -> done one cycle later, no fill_start.
//  rst_n=0 during F_WAIT of layer 1: all outputs 0 next edge; new cfg_start restarts at layer 0 bank 0.
//  NOISE_SEQ_WATCHDOG_EN with fill_done held low: cfg_err at WDOG_CYCLES, busy drops, no done.

Source files
------------

// File: rtl/noise_layer_sequencer_pkg.sv
// Shared constants, FSM encodings and size-code helpers for the noise layer sequencer.
// Size code s selects a square matrix of side (4 << s); codes 0..SIZE_MAX fit the filler address space.
package noise_layer_sequencer_pkg;

    localparam int SIZE_MAX   = 5;
    localparam int MAX_LAYERS = 6;
    localparam int SIDE_BASE  = 4;

    typedef enum logic [1:0] {
        TOP_IDLE = 2'd0,
        TOP_RUN  = 2'd1,
        TOP_FIN  = 2'd2
    } top_state_t;

    typedef enum logic [1:0] {
        F_IDLE  = 2'd0,
        F_START = 2'd1,
        F_WAIT  = 2'd2
    } fill_state_t;

    function automatic int unsigned size_side(input logic [2:0] code);
        return SIDE_BASE << code;
    endfunction

    function automatic int unsigned size_words(input logic [2:0] code);
        return size_side(code) * size_side(code);
    endfunction

    // A sequence is rejected when the last layer's size code would pass SIZE_MAX.
    function automatic logic cfg_invalid(input logic [2:0] base, input logic [2:0] num);
        logic [3:0] last_plus_one;
        last_plus_one = {1'b0, base} + {1'b0, num};
        return (num > 3'(MAX_LAYERS)) || (last_plus_one > 4'(SIZE_MAX + 1));
    endfunction

endpackage

// File: rtl/noise_layer_sequencer_bank_tracker.sv
// Ping-pong bank occupancy: full flags plus independent write (filler) and read (consumer) pointers.
// A fill completion and a release may land on the same edge; each touches its own bank.
module noise_layer_sequencer_bank_tracker (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       fill_ack,
    input  logic       release_ack,
    output logic [1:0] full,
    output logic       wr_bank,
    output logic       rd_bank
);

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            full    <= 2'b00;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
        end else begin
            // NOTE: non-blocking updates mean both branches index with the pre-edge pointers,
            // so a simultaneous fill and release each hit the correct bank.
            if (fill_ack) begin
                full[wr_bank] <= 1'b1;
                wr_bank       <= ~wr_bank;
            end
            if (release_ack) begin
                full[rd_bank] <= 1'b0;
                rd_bank       <= ~rd_bank;
            end
        end
    end

endmodule

// File: rtl/noise_layer_sequencer.sv
// Schedules per-layer noise fills into two ping-pong banks and presents filled banks to the consumer.
// Optional NOISE_SEQ_WATCHDOG_EN aborts a sequence when a fill never completes.
module noise_layer_sequencer #(
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 14,
    parameter int WDOG_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cfg_start,
    input  logic [2:0] cfg_num_layers,
    input  logic [2:0] cfg_base_size,
    output logic       busy,
    output logic       done,
    output logic       cfg_err,
    output logic       fill_start,
    output logic [2:0] fill_size,
    output logic       fill_bank,
    input  logic       fill_done,
    output logic       layer_valid,
    output logic       layer_bank,
    output logic [2:0] layer_size,
    output logic [2:0] layer_idx,
    input  logic       layer_release
);
    import noise_layer_sequencer_pkg::*;

    top_state_t  top_state;
    fill_state_t fill_state;

    logic [2:0] base_size;
    logic [2:0] num_layers;
    logic [2:0] fill_idx;
    logic [2:0] rel_idx;

    logic [1:0] full;
    logic       wr_bank;
    logic       rd_bank;

    logic accept;
    logic reject;
    logic fill_ack;
    logic release_ack;
    logic wdog_trip;
    logic tracker_clear;

    assign accept        = (top_state == TOP_IDLE) && cfg_start && !cfg_invalid(cfg_base_size, cfg_num_layers);
    assign reject        = (top_state == TOP_IDLE) && cfg_start &&  cfg_invalid(cfg_base_size, cfg_num_layers);
    assign fill_ack      = (fill_state == F_WAIT) && fill_done;
    assign release_ack   = layer_release && layer_valid;
    assign tracker_clear = accept || wdog_trip;

`ifdef NOISE_SEQ_WATCHDOG_EN
    logic [14:0] wdog_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || fill_state != F_WAIT || fill_done) begin
            wdog_cnt <= '0;
        end else begin
            wdog_cnt <= wdog_cnt + 15'd1;
        end
    end

    assign wdog_trip = (fill_state == F_WAIT) && !fill_done && (wdog_cnt == 15'(WDOG_CYCLES - 1));
`else
    assign wdog_trip = 1'b0;
`endif

    noise_layer_sequencer_bank_tracker u_tracker (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (tracker_clear),
        .fill_ack    (fill_ack),
        .release_ack (release_ack),
        .full        (full),
        .wr_bank     (wr_bank),
        .rd_bank     (rd_bank)
    );

    // Sequence control: accept/reject config, count releases, emit done.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous, so it lives inside the clocked block rather than the sensitivity list.
        if (!rst_n) begin
            top_state  <= TOP_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            cfg_err    <= 1'b0;
            base_size  <= '0;
            num_layers <= '0;
            rel_idx    <= '0;
        end else begin
            done <= 1'b0;
            case (top_state)
                TOP_IDLE: begin
                    if (accept) begin
                        base_size  <= cfg_base_size;
                        num_layers <= cfg_num_layers;
                        rel_idx    <= '0;
                        cfg_err    <= 1'b0;
                        busy       <= 1'b1;
                        if (cfg_num_layers == 3'd0) begin
                            top_state <= TOP_FIN;
                            done      <= 1'b1;
                        end else begin
                            top_state <= TOP_RUN;
                        end
                    end else if (reject) begin
                        cfg_err <= 1'b1;
                    end
                end
                TOP_RUN: begin
                    if (wdog_trip) begin
                        top_state <= TOP_IDLE;
                        busy      <= 1'b0;
                        cfg_err   <= 1'b1;
                    end else begin
                        if (release_ack) begin
                            rel_idx <= rel_idx + 3'd1;
                        end
                        if (rel_idx == num_layers) begin
                            top_state <= TOP_FIN;
                            done      <= 1'b1;
                        end
                    end
                end
                TOP_FIN: begin
                    top_state <= TOP_IDLE;
                    busy      <= 1'b0;
                end
                default: begin
                    top_state <= TOP_IDLE;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    // Fill scheduling: only launches into a bank whose full flag is clear, which gives back-pressure.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fill_state <= F_IDLE;
            fill_start <= 1'b0;
            fill_size  <= '0;
            fill_bank  <= 1'b0;
            fill_idx   <= '0;
        end else begin
            fill_start <= 1'b0;
            if (tracker_clear) begin
                fill_state <= F_IDLE;
                fill_idx   <= '0;
            end else begin
                case (fill_state)
                    F_IDLE: begin
                        if (top_state == TOP_RUN && fill_idx < num_layers && !full[wr_bank]) begin
                            fill_state <= F_START;
                        end
                    end
                    F_START: begin
                        fill_start <= 1'b1;
                        fill_size  <= base_size + fill_idx;
                        fill_bank  <= wr_bank;
                        fill_state <= F_WAIT;
                    end
                    F_WAIT: begin
                        if (fill_done) begin
                            fill_idx   <= fill_idx + 3'd1;
                            fill_state <= F_IDLE;
                        end
                    end
                    default: fill_state <= F_IDLE;
                endcase
            end
        end
    end

    // A release forces one low cycle so the consumer never sees the old bank as still valid.
    always_ff @(posedge clk) begin
        if (!rst_n || tracker_clear || release_ack) begin
            layer_valid <= 1'b0;
        end else begin
            layer_valid <= full[rd_bank];
        end
    end

    assign layer_bank = rd_bank;
    assign layer_idx  = rel_idx;
    assign layer_size = base_size + rel_idx;

endmodule
